// File: rtl/sha256_msg_padder.sv
// Byte-stream SHA-256 message padder: buffers one 64-byte block, then emits it
// byte-serially to the core with 0x80 marker, zero fill and 64-bit bit length.
module sha256_msg_padder #(
  parameter int LEN_W = 32,
  parameter int GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  input  logic       core_busy,
  output logic [7:0] data,
  output logic       write_enable,
  output logic       first_block,
  output logic       last_block
);
  localparam int            GW    = $clog2(GAP + 2);
  localparam logic [GW-1:0] GAP_C = GW'(GAP);

  typedef enum logic [1:0] {FILL, WAIT, EMIT} state_e;
  typedef enum logic [1:0] {K_DATA, K_FINAL, K_SPILL} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [6:0]       n_q, n_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pend_q, pend_d;
  logic             trailer_q, trailer_d;
  logic             marker_q, marker_d;
  logic             mid_q, mid_d;
  logic             ready_q, ready_d;
  logic [7:0]       data_q, data_d;
  logic             we_q, we_d, fb_q, fb_d, lb_q, lb_d;
  logic [7:0]       mbuf_q [64];

  logic        xfer, blk_last, mark_set;
  logic [5:0]  bidx;
  logic [7:0]  gen_byte;
  logic [63:0] len_bits;

  assign xfer     = msg_valid & ready_q;
  assign blk_last = (kind_q == K_FINAL) | trailer_q;
  // Outputs are registered, so generate the byte that will be on the wire next cycle.
  assign bidx     = (state_q == EMIT) ? idx_q + 6'd1 : 6'd0;
  assign len_bits = 64'({len_q, 3'b000});

  always_comb begin
    gen_byte = 8'h00;
    mark_set = 1'b0;
    if ({1'b0, bidx} < n_q) begin
      gen_byte = mbuf_q[bidx];
    end else if ({1'b0, bidx} == n_q && !marker_q) begin
      gen_byte = 8'h80;
      mark_set = 1'b1;
    end else if (blk_last && bidx >= 6'd56) begin
      gen_byte = len_bits[{~bidx[2:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    n_d       = n_q;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_d     = (gap_q < GAP_C) ? gap_q + GW'(1) : gap_q;
    pend_d    = pend_q;
    trailer_d = trailer_q;
    marker_d  = marker_q;
    mid_d     = mid_q;
    data_d    = 8'h00;
    we_d      = 1'b0;
    fb_d      = 1'b0;
    lb_d      = 1'b0;
    case (state_q)
      FILL: begin
        if (xfer) begin
          n_d   = n_q + 7'd1;
          len_d = len_q + LEN_W'(1);
          if (msg_last) begin
            state_d = WAIT;
            if (n_d <= 7'd55)      kind_d = K_FINAL;
            else if (n_d <= 7'd63) kind_d = K_SPILL;
            else begin
              kind_d = K_DATA;
              pend_d = 1'b1;
            end
          end else if (n_d == 7'd64) begin
            state_d = WAIT;
            kind_d  = K_DATA;
          end
        end
      end
      WAIT: begin
        // The first block of a message does not wait out the inter-block gap.
        if (!core_busy && (!mid_q || gap_q >= GAP_C)) begin
          state_d  = EMIT;
          idx_d    = 6'd0;
          data_d   = gen_byte;
          marker_d = marker_q | mark_set;
          we_d     = 1'b1;
          fb_d     = !mid_q;
          lb_d     = blk_last;
        end
      end
      EMIT: begin
        if (idx_q == 6'd63) begin
          gap_d = '0;
          n_d   = 7'd0;
          mid_d = 1'b1;
          if (blk_last) begin
            state_d   = FILL;
            kind_d    = K_DATA;
            len_d     = '0;
            pend_d    = 1'b0;
            trailer_d = 1'b0;
            marker_d  = 1'b0;
            mid_d     = 1'b0;
          end else if (kind_q == K_SPILL || pend_q) begin
            state_d   = WAIT;
            trailer_d = 1'b1;
            pend_d    = 1'b0;
          end else begin
            state_d = FILL;
          end
        end else begin
          idx_d    = idx_q + 6'd1;
          data_d   = gen_byte;
          marker_d = marker_q | mark_set;
          we_d     = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      kind_q    <= K_DATA;
      n_q       <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      pend_q    <= 1'b0;
      trailer_q <= 1'b0;
      marker_q  <= 1'b0;
      mid_q     <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= 8'h00;
      we_q      <= 1'b0;
      fb_q      <= 1'b0;
      lb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      trailer_q <= trailer_d;
      marker_q  <= marker_d;
      mid_q     <= mid_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      we_q      <= we_d;
      fb_q      <= fb_d;
      lb_q      <= lb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mbuf_q[n_q[5:0]] <= msg_data;
  end

  assign msg_ready    = ready_q;
  assign data         = data_q;
  assign write_enable = we_q;
  assign first_block  = fb_q;
  assign last_block   = lb_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: captures every emitted byte and checks
// padded blocks, block flags, inter-block gaps, busy stalls and reset abort.
module tb_sha256_msg_padder;
  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_valid = 1'b0, msg_last = 1'b0, core_busy = 1'b0;
  logic       msg_ready, write_enable, first_block, last_block;
  logic [7:0] data;

  int checks = 0, errors = 0;
  logic [7:0] cap[$];
  logic       cfb[$], clb[$];
  int         gaps[$], runs[$];
  int         run = 0, idle = 0, stray = 0;
  logic [7:0] exp_q[$];

  sha256_msg_padder #(.LEN_W(32), .GAP(3)) dut (
    .clk(clk), .reset(reset), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_ready(msg_ready), .core_busy(core_busy),
    .data(data), .write_enable(write_enable), .first_block(first_block),
    .last_block(last_block)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (write_enable === 1'b1) begin
        if (run == 0) begin
          gaps.push_back(idle);
          cfb.push_back(first_block);
          clb.push_back(last_block);
        end else if (first_block !== 1'b0 || last_block !== 1'b0) begin
          stray++;
        end
        cap.push_back(data);
        run++;
        idle = 0;
      end else begin
        if (run > 0) runs.push_back(run);
        run = 0;
        idle++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_cap();
    cap.delete(); cfb.delete(); clb.delete(); gaps.delete(); runs.delete();
    run = 0; idle = 0; stray = 0;
  endtask

  task automatic send_msg(input bq_t m, input string nm);
    int k = 0;
    int t = 0;
    logic rdy;
    while (k < m.size() && t < 2000) begin
      @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = m[k];
      msg_last  = (k == m.size() - 1);
      rdy = msg_ready;
      @(posedge clk);
      if (rdy === 1'b1) k++;
      t++;
    end
    #1;
    msg_valid = 1'b0; msg_last = 1'b0; msg_data = 8'h00;
    if (k < m.size()) begin
      checks++; errors++;
      $display("FAIL %s send: accepted %0d bytes, required %0d", nm, k, m.size());
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while ((cap.size() < n || write_enable === 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({msg_ready, write_enable, first_block, last_block, data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %03h required 000", {msg_ready, write_enable, first_block, last_block, data});
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", msg_ready);
    end
  endtask

  task automatic test_abc(input string nm);
    bq_t m;
    int bad = -1;
    logic [7:0] g;
    clear_cap();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    send_msg(m, nm);
    wait_done(64);
    exp_q.delete();
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h80);
    repeat (59) exp_q.push_back(8'h00);
    exp_q.push_back(8'h18);
    checks++;
    if (cap.size() != 64) begin errors++; $display("FAIL %s count: got %0d required 64", nm, cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      g = (bad < cap.size()) ? cap[bad] : 8'hxx;
      errors++; $display("FAIL %s data: byte %0d got %02h required %02h", nm, bad, g, exp_q[bad]);
    end
    checks++;
    if (cfb.size() != 1 || cfb[0] !== 1'b1 || clb[0] !== 1'b1 || stray != 0) begin
      errors++; $display("FAIL %s flags: blocks %0d fb %b lb %b stray %0d, required 1 1 1 0", nm, cfb.size(), cfb[0], clb[0], stray);
    end
  endtask

  task automatic test_spill56();
    bq_t m;
    int bad = -1, br = 0;
    logic [7:0] g;
    clear_cap();
    repeat (56) m.push_back(8'h30);
    send_msg(m, "spill56");
    wait_done(128);
    exp_q.delete();
    repeat (56) exp_q.push_back(8'h30);
    exp_q.push_back(8'h80);
    repeat (7 + 62) exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'hC0);
    checks++;
    if (cap.size() != 128) begin errors++; $display("FAIL spill56 count: got %0d required 128", cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      g = (bad < cap.size()) ? cap[bad] : 8'hxx;
      errors++; $display("FAIL spill56 data: byte %0d got %02h required %02h", bad, g, exp_q[bad]);
    end
    checks++;
    if (cfb.size() != 2 || {cfb[1], cfb[0]} !== 2'b01 || {clb[1], clb[0]} !== 2'b10) begin
      errors++; $display("FAIL spill56 flags: blocks %0d, required 2 blocks fb=01 lb=10", cfb.size());
    end
    foreach (runs[i]) if (runs[i] != 64) br++;
    foreach (gaps[i]) if (i > 0 && gaps[i] < 3) br++;
    checks++;
    if (br != 0 || runs.size() != 2) begin
      errors++; $display("FAIL spill56 framing: %0d bad runs/gaps, %0d runs, required 0 and 2", br, runs.size());
    end
  endtask

  task automatic test_exact64();
    bq_t m;
    int bad = -1, br = 0;
    logic [7:0] g;
    clear_cap();
    repeat (64) m.push_back(8'h30);
    send_msg(m, "exact64");
    wait_done(128);
    exp_q.delete();
    repeat (64) exp_q.push_back(8'h30);
    exp_q.push_back(8'h80);
    repeat (61) exp_q.push_back(8'h00);
    exp_q.push_back(8'h02); exp_q.push_back(8'h00);
    checks++;
    if (cap.size() != 128) begin errors++; $display("FAIL exact64 count: got %0d required 128", cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      g = (bad < cap.size()) ? cap[bad] : 8'hxx;
      errors++; $display("FAIL exact64 data: byte %0d got %02h required %02h", bad, g, exp_q[bad]);
    end
    checks++;
    if (cfb.size() != 2 || {cfb[1], cfb[0]} !== 2'b01 || {clb[1], clb[0]} !== 2'b10) begin
      errors++; $display("FAIL exact64 flags: blocks %0d, required 2 blocks fb=01 lb=10", cfb.size());
    end
    foreach (gaps[i]) if (i > 0 && gaps[i] < 3) br++;
    checks++;
    if (br != 0) begin errors++; $display("FAIL exact64 gap: %0d short gaps, required 0", br); end
  endtask

  task automatic test_three_blocks();
    bq_t m;
    int bad = -1, br = 0;
    logic [7:0] g;
    clear_cap();
    repeat (120) m.push_back(8'h30);
    send_msg(m, "three_blocks");
    wait_done(192);
    exp_q.delete();
    repeat (64 + 56) exp_q.push_back(8'h30);
    exp_q.push_back(8'h80);
    repeat (7 + 62) exp_q.push_back(8'h00);
    exp_q.push_back(8'h03); exp_q.push_back(8'hC0);
    checks++;
    if (cap.size() != 192) begin errors++; $display("FAIL three_blocks count: got %0d required 192", cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      g = (bad < cap.size()) ? cap[bad] : 8'hxx;
      errors++; $display("FAIL three_blocks data: byte %0d got %02h required %02h", bad, g, exp_q[bad]);
    end
    checks++;
    if (cfb.size() != 3 || {cfb[2], cfb[1], cfb[0]} !== 3'b001 || {clb[2], clb[1], clb[0]} !== 3'b100) begin
      errors++; $display("FAIL three_blocks flags: blocks %0d, required 3 blocks fb=001 lb=100", cfb.size());
    end
    foreach (runs[i]) if (runs[i] != 64) br++;
    foreach (gaps[i]) if (i > 0 && gaps[i] < 3) br++;
    checks++;
    if (br != 0) begin errors++; $display("FAIL three_blocks framing: %0d bad runs/gaps, required 0", br); end
  endtask

  task automatic test_busy();
    bq_t m;
    int t = 0, early = 0;
    clear_cap();
    repeat (56) m.push_back(8'h30);
    send_msg(m, "busy");
    while (write_enable !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    while (write_enable === 1'b1 && t < 600) begin @(negedge clk); t++; end
    core_busy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (write_enable !== 1'b0) early++;
    end
    core_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (early != 0 || write_enable !== 1'b1 || last_block !== 1'b1) begin
      errors++;
      $display("FAIL busy_stall: early %0d we %b lb %b, required 0 1 1", early, write_enable, last_block);
    end
    wait_done(128);
    checks++;
    if (cap.size() != 128) begin errors++; $display("FAIL busy count: got %0d required 128", cap.size()); end
  endtask

  task automatic test_back_to_back();
    bq_t m1, m2;
    int bad = -1;
    logic [7:0] g;
    clear_cap();
    m1.push_back(8'h61); m1.push_back(8'h62); m1.push_back(8'h63);
    m2.push_back(8'h61); m2.push_back(8'h62);
    send_msg(m1, "b2b_first");
    send_msg(m2, "b2b_second");
    wait_done(128);
    exp_q.delete();
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h80);
    repeat (59) exp_q.push_back(8'h00);
    exp_q.push_back(8'h18);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h80);
    repeat (60) exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    checks++;
    if (cap.size() != 128) begin errors++; $display("FAIL b2b count: got %0d required 128", cap.size()); end
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      g = (bad < cap.size()) ? cap[bad] : 8'hxx;
      errors++; $display("FAIL b2b data: byte %0d got %02h required %02h", bad, g, exp_q[bad]);
    end
    checks++;
    if (cfb.size() != 2 || {cfb[1], cfb[0]} !== 2'b11 || {clb[1], clb[0]} !== 2'b11) begin
      errors++; $display("FAIL b2b flags: blocks %0d, required 2 blocks fb=11 lb=11", cfb.size());
    end
  endtask

  task automatic test_reset_mid();
    bq_t m;
    int t = 0;
    clear_cap();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    send_msg(m, "reset_mid");
    while (write_enable !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    checks++;
    if (write_enable !== 1'b1) begin errors++; $display("FAIL reset_mid pre: we %b required 1", write_enable); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({msg_ready, write_enable, first_block, last_block, data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid async: got %03h required 000", {msg_ready, write_enable, first_block, last_block, data});
    end
    @(negedge clk); @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid ready: got %b required 1", msg_ready); end
    #1 clear_cap();
    repeat (80) @(negedge clk);
    checks++;
    if (cap.size() != 0) begin errors++; $display("FAIL reset_mid resume: %0d bytes emitted, required 0", cap.size()); end
    #1;
    test_abc("abc_after_reset");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_spill56();
    test_exact64();
    test_three_blocks();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream neighbour of the SHA-256 core. Accepts a raw message as a byte stream and emits the padded 512-bit blocks to the core's byte-serial write port.
- Drives the core's write port (data, write_enable, first_block, last_block) and honours the core's busy.
- Inserts the 0x80 marker, the zero fill and the 64-bit big-endian bit length, so upstream logic never handles padding.
- Buffers one 64-byte block internally, because last_block must be known before a block's first byte is sent.

Parameters:
- LEN_W, 32: width of the message byte counter. Maximum message length is 2^LEN_W-1 bytes. The emitted bit length is {byte_count,3'b000}, zero-extended to 64 bits.
- GAP, 3: minimum number of idle cycles with write_enable low between consecutive blocks sent to the core.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- msg_data  input  8  message byte.
- msg_valid  input  1  msg_data is valid.
- msg_last  input  1  qualifies msg_valid; marks the final byte of the message. Messages are at least 1 byte long.
- msg_ready  output  1  padder accepts a byte this cycle; transfer = msg_valid & msg_ready.
- core_busy  input  1  busy from the SHA-256 core; no block starts while it is high.
- data  output  8  byte to the core.
- write_enable  output  1  data is valid for the core.
- first_block  output  1  high with byte 0 of the first block of a message.
- last_block  output  1  high with byte 0 of the final (length-bearing) block.

Behaviour:
- Reset (reset low, asynchronous): state=FILL; all counters and flags cleared; msg_ready=0, data=0x00, write_enable=0, first_block=0, last_block=0.
- msg_ready goes high in the first cycle after reset deasserts.
- A reset mid-block aborts that block immediately. No partial output is completed after release.
- States: FILL, WAIT, EMIT.
- FILL:
  - msg_ready=1.
  - Each transfer writes buf[n] and increments n (bytes in this block) and the message byte counter.
  - A transfer of byte 64 without msg_last: kind=DATA, go to WAIT.
  - A transfer with msg_last: go to WAIT, with kind set by the final n:
    - n<=55: kind=FINAL.
    - 56..63: kind=SPILL.
    - n=64: kind=DATA and trailer_pending=1.
- WAIT:
  - msg_ready=0; outputs idle.
  - The gap counter counts idle cycles since the previous block's last byte (a new message ignores the gap).
  - Go to EMIT when gap>=GAP and core_busy=0 in the same cycle.
- EMIT:
  - 64 consecutive cycles, i=0..63, with write_enable=1 and msg_ready=0.
  - Byte generation for data:
    - i<n: data=buf[i].
    - i==n and marker not yet placed: data=0x80, set marker_done.
    - Block is last and i>=56: data=length byte, with i=56 the MSB and i=63 the LSB.
    - Otherwise: data=0x00.
  - first_block=1 at i=0 if this is the message's first block.
  - last_block=1 at i=0 if kind=FINAL or this is a trailer block.
  - A block is never interrupted by core_busy.
- After EMIT:
  - kind=FINAL or trailer block: message done; clear counters; go to FILL.
  - kind=SPILL or trailer_pending: go to WAIT and then emit a trailer block. The trailer uses n=0, so it carries 0x80 at byte 0 only if marker_done=0, then zeros, then the length.
  - Otherwise: go to FILL.
- No input is accepted while in WAIT or EMIT; upstream stalls via msg_ready.
- msg_valid while msg_ready=0 is ignored. msg_last without msg_valid is ignored.
- Counter overflow beyond 2^LEN_W-1 bytes is undefined and is not checked.

Test Plan:
- "abc" (61 62 63, last on 0x63) -> one block: 61 62 63 80, zeros, byte63=0x18; first_block and last_block both high at byte 0.
- 56×0x30 ->
  - Block 1: bytes 0..55=0x30, byte56=0x80, rest 0x00; first_block=1, last_block=0.
  - Gap of at least 3 cycles.
  - Block 2: all zeros except byte62=0x01, byte63=0xC0; last_block=1.
  - The core then returns digest bd03ac14...857ffc18.
- 64×0x30 -> block 1 is pure data. Block 2 is 0x80 at byte 0, zeros, byte62=0x02, byte63=0x00, with last_block=1.
- 120×0x30 -> three blocks; the 0x80 is at block-2 byte 56; block 3 ends 0x03C0; digest 09719c55...8c7eedab.
- core_busy held high for 20 cycles after block 1 -> write_enable stays low and block 2 starts the first cycle busy is low. Back-to-back messages: the second message has first_block=1 again.
- reset pulsed low at EMIT byte 30 -> outputs drop to 0 asynchronously. After release, msg_ready=1 and a fresh "abc" pads correctly.
